// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter and its owner FIFO.
package bus_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int BE_W       = 4;

  // Identifies which master issued an outstanding transfer
  typedef logic mid_t;

  localparam mid_t M_CORE = 1'b0;
  localparam mid_t M_DMA  = 1'b1;

endpackage

// File: rtl/owner_fifo.sv
// Synchronous FIFO of master IDs, one entry per outstanding bus transfer.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally and the
// count MSB doubles as the full flag.
module owner_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  mid_t                     din,
  input  logic                     pop,
  output mid_t                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  mid_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = count[PTR_W];
  assign empty   = (count == '0);
  assign head    = mem[rptr];
  // Writes into a full FIFO and reads from an empty one are dropped
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage needs no reset: entries are only read when count says valid
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the single-port data bus.
// Master 0 is the core LSU, master 1 the DMA/debug agent. Outstanding
// transfers are recorded in an owner FIFO so in-order responses can be
// steered back to the issuing master.
// Optional: define ARB_LOCK_EN to let the last-granted master keep the bus
// while it holds its lock input together with its request.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MAX_OUT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [BE_W-1:0]   m0_be_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  input  logic              m0_lock_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [BE_W-1:0]   m1_be_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  input  logic              m1_lock_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m_rdata_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [BE_W-1:0]   bus_be_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  output logic              err_o
);

  mid_t                    last_grant;
  mid_t                    sel;
  logic                    sel_valid;
  logic                    fwd_dma;
  logic                    grant;
  logic                    pop;
  mid_t                    head;
  logic                    full;
  logic                    empty;
  logic [$clog2(MAX_OUT):0] fifo_count;

`ifndef ARB_LOCK_EN
  // Lock inputs are part of the port list in every build
  logic unused_lock;
  assign unused_lock = &{1'b0, m0_lock_i, m1_lock_i};
`endif

  logic unused_count;
  assign unused_count = &{1'b0, fifo_count};

  // Round-robin pick; a tie goes to whoever did not win last time
  always_comb begin
    sel = M_CORE;
    case ({m1_req_i, m0_req_i})
      2'b01: sel = M_CORE;
      2'b10: sel = M_DMA;
      2'b11: begin
        sel = ~last_grant;
`ifdef ARB_LOCK_EN
        // Last winner keeps the bus while it alone holds lock; lock only
        // matters with its request up, so it can never stall the bus
        if (last_grant == M_CORE) begin
          if (m0_lock_i && !m1_lock_i) sel = M_CORE;
        end else begin
          if (m1_lock_i && !m0_lock_i) sel = M_DMA;
        end
`endif
      end
      default: sel = M_CORE;
    endcase
  end

  // A full owner FIFO blocks forwarding even if a pop happens this cycle
  assign sel_valid = (m0_req_i | m1_req_i) & ~full;
  assign fwd_dma   = sel_valid & (sel == M_DMA);
  assign grant     = sel_valid & bus_gnt_i;

  assign bus_req_o   = sel_valid;
  assign bus_we_o    = fwd_dma ? m1_we_i    : m0_we_i;
  assign bus_be_o    = fwd_dma ? m1_be_i    : m0_be_i;
  assign bus_addr_o  = fwd_dma ? m1_addr_i  : m0_addr_i;
  assign bus_wdata_o = fwd_dma ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o = grant & (sel == M_CORE);
  assign m1_gnt_o = grant & (sel == M_DMA);

  // Responses come back in issue order, so the FIFO head owns this one
  assign pop         = bus_rvalid_i & ~empty;
  assign m0_rvalid_o = pop & (head == M_CORE);
  assign m1_rvalid_o = pop & (head == M_DMA);
  assign m_rdata_o   = bus_rdata_i;

  owner_fifo #(
    .DEPTH (MAX_OUT)
  ) u_owner_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (grant),
    .din   (sel),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // Round-robin history and sticky error on a response nobody asked for
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= M_DMA;
      err_o      <= 1'b0;
    end else begin
      if (grant) last_grant <= sel;
      if (bus_rvalid_i && empty) err_o <= 1'b1;
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter in front of the single-port peripheral/memory data bus.
- Master 0 is the core load/store unit; master 1 is a DMA/debug agent.
- Forwards one request per cycle to the bus using round-robin selection.
- Tracks outstanding transfers in an owner FIFO and routes each bus response back to the master that issued it.

Parameters:
- ADDR_W, 15, request address width (bit 14 selects peripherals vs data memory).
- MAX_OUT, 2, maximum outstanding transfers (owner FIFO depth, power of two ≥ 2).

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- m0_req_i, m1_req_i  in  1  master request
- m0_we_i, m1_we_i  in  1  write enable
- m0_be_i, m1_be_i  in  4  byte enables
- m0_addr_i, m1_addr_i  in  ADDR_W  word address
- m0_wdata_i, m1_wdata_i  in  32  write data
- m0_gnt_o, m1_gnt_o  out  1  request accepted this cycle
- m0_rvalid_o, m1_rvalid_o  out  1  response valid for that master
- m_rdata_o  out  32  response data, broadcast to both masters
- bus_req_o, bus_we_o  out  1  forwarded request / write enable
- bus_be_o  out  4  forwarded byte enables
- bus_addr_o  out  ADDR_W  forwarded address
- bus_wdata_o  out  32  forwarded write data
- bus_gnt_i  in  1  bus accepts the request this cycle
- bus_rvalid_i  in  1  bus response valid (reads and writes)
- bus_rdata_i  in  32  bus response data
- m0_lock_i, m1_lock_i  in  1  hold arbitration (only with ARB_LOCK_EN)
- err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous, active-high.
- Reset state:
  - FIFO empty; count = 0.
  - last_grant = 1, so master 0 wins the first tie.
  - err_o = 0.
- Selection is combinational, with zero added request latency:
  - Only one master requesting: that master is selected.
  - Both requesting: select the master that is not last_grant.
  - sel is valid only when at least one req is high and count < MAX_OUT.
- Forwarding: bus_req_o = sel_valid. bus_we/be/addr/wdata are muxed from the selected master; they are don't-care when bus_req_o = 0 and are driven with master 0 fields.
- Grant: mX_gnt_o = sel_valid & (sel == X) & bus_gnt_i. At most one grant per cycle.
- On a grant edge: push sel into the owner FIFO and set last_grant = sel.
- Bus stall: bus_gnt_i = 0 with bus_req_o = 1 means no grant and no push. The selection may change next cycle; masters must hold their requests until granted.
- Responses:
  - On bus_rvalid_i, pop the FIFO head and assert m<head>_rvalid_o in the same cycle (combinational).
  - m_rdata_o = bus_rdata_i, combinational passthrough.
  - Responses return in issue order.
- Simultaneous push and pop in one cycle: count unchanged; FIFO pointers both advance.
- FIFO full (count == MAX_OUT): bus_req_o = 0 and no grants. A pop in the same cycle does not unblock that cycle; the request proceeds next cycle.
- bus_rvalid_i with FIFO empty: no master rvalid, no pop, err_o set to 1 until reset.
- Reset mid-transfer: outstanding entries are discarded, and later stray rvalids set err_o. The system resets the bus together with the arbiter.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - If last_grant master X holds mX_lock_i = 1 and mX_req_i = 1, X wins regardless of the other request.
  - Lock is ignored when mX_req_i = 0, so a lock never stalls the bus.
  - Both masters locked: round-robin as usual.
- Undefined: lock inputs exist but are unused; pure round-robin.

Decomposition:
- Shared package bus_pkg:
  - Constants ADDR_W_DEF = 15 and BE_W = 4.
  - Master-ID typedef (1 bit).
  - Localparams M_CORE = 0 and M_DMA = 1.
- One sub-module: owner_fifo. Synchronous FIFO with parameter DEPTH and width 1; provides push/pop, head, count, full, empty. It is reused by future bus bridges.

Test Plan:
- Reset, then m0 read at addr 0x0010 with bus_gnt_i = 1 and bus_rvalid_i the next cycle with rdata 0xDEADBEEF:
  - m0_gnt_o in cycle 0.
  - m0_rvalid_o = 1 and m_rdata_o = 0xDEADBEEF in cycle 1.
  - m1_rvalid_o = 0.
- Both masters requesting continuously for 6 cycles, 1-cycle bus latency: grants alternate m0, m1, m0, m1, m0, m1, and rvalids follow the same order one cycle later.
- bus_gnt_i held 0 for 3 cycles with m1 requesting: no m1_gnt_o and no push. Raise bus_gnt_i: m1_gnt_o is asserted that cycle with the address forwarded unchanged.
- Withhold bus_rvalid_i after 2 grants (MAX_OUT = 2): bus_req_o = 0 while full. Pulse rvalid: m0 response routed, and the next request is forwarded the following cycle.
- bus_rvalid_i with the FIFO empty right after reset: err_o = 1 and stays 1 until rst_i; no master rvalid.
- ARB_LOCK_EN: m1 granted with m1_lock_i = 1 and both requesting for 4 cycles: m1 is granted all 4 cycles. Drop the lock: the next grant goes to m0.
